// File: rtl/ir_sink_pwm_ctrl.sv
// ir_sink_pwm_ctrl: IR illuminator sink-bank controller.
// PWM or one-shot drive with soft-start ramp and on-time cut-off.
module ir_sink_pwm_ctrl #(
  parameter int NGRP    = 8,
  parameter int PWM_W   = 8,
  parameter int TIME_W  = 16,
  parameter int RAMP_SH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      mode,
  input  logic                      trig,
  input  logic [$clog2(NGRP+1)-1:0] level,
  input  logic [PWM_W-1:0]          duty,
  input  logic [TIME_W-1:0]         pulse_len,
  input  logic [TIME_W-1:0]         max_on,
  output logic [NGRP-1:0]           ng_en,
  output logic                      busy,
  output logic                      fault
);

  localparam int LW = $clog2(NGRP+1);
  localparam int RW = (RAMP_SH > 0) ? RAMP_SH : 1;
  localparam logic [RW-1:0] RMAX = RW'((1 << RAMP_SH) - 1);

  typedef enum logic [1:0] {
    IDLE,
    PWM,
    PULSE,
    FLT
  } state_t;

  state_t state, state_nx;
  logic [PWM_W-1:0]  pwm_cnt, pwm_cnt_nx;
  logic [PWM_W-1:0]  duty_q, duty_q_nx, duty_cur;
  logic [TIME_W-1:0] on_cnt, on_cnt_nx;
  logic [TIME_W-1:0] on_run, on_run_nx;
  logic [LW-1:0]     cur_lvl, cur_lvl_nx, lvl;
  logic [RW-1:0]     ramp_cnt, ramp_cnt_nx;
  logic [NGRP-1:0]   therm;
  logic              on_c, drive;

  always_comb begin
    state_nx   = state;
    pwm_cnt_nx = pwm_cnt;
    duty_q_nx  = duty_q;
    on_cnt_nx  = on_cnt;
    on_c       = 1'b0;
    lvl        = (level > LW'(NGRP)) ? LW'(NGRP) : level;
    duty_cur   = (pwm_cnt == '0) ? duty : duty_q;

    unique case (state)
      IDLE: begin
        if (enable && !mode) begin
          state_nx   = PWM;
          pwm_cnt_nx = '0;
        end else if (enable && mode && trig) begin
          state_nx  = PULSE;
          on_cnt_nx = pulse_len;
        end
      end
      PWM: begin
        on_c       = (pwm_cnt < duty_cur);
        duty_q_nx  = duty_cur;
        pwm_cnt_nx = pwm_cnt + 1'b1;
      end
      PULSE: begin
        on_c = (on_cnt != '0);
        if (on_cnt < TIME_W'(2)) state_nx = IDLE;
        if (on_cnt != '0) on_cnt_nx = on_cnt - 1'b1;
      end
      FLT: ;
    endcase

    drive = enable && on_c && (lvl != '0);

    on_run_nx = '0;
    if (drive)
      on_run_nx = (&on_run) ? on_run : on_run + 1'b1;

    // Cut-off wins over normal pulse completion in the same cycle
    if (drive && (max_on != '0) && (on_run_nx == max_on))
      state_nx = FLT;
    if (!enable)
      state_nx = IDLE;

    cur_lvl_nx  = '0;
    ramp_cnt_nx = '0;
    if (drive) begin
      if (cur_lvl == '0) begin
        cur_lvl_nx = LW'(1);
      end else if (lvl < cur_lvl) begin
        cur_lvl_nx = lvl;
      end else if (cur_lvl < lvl) begin
        cur_lvl_nx = cur_lvl;
        if (ramp_cnt == RMAX) cur_lvl_nx = cur_lvl + 1'b1;
        else ramp_cnt_nx = ramp_cnt + 1'b1;
      end else begin
        cur_lvl_nx = cur_lvl;
      end
    end

    for (int i = 0; i < NGRP; i++)
      therm[i] = (LW'(i) < cur_lvl_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pwm_cnt  <= '0;
      duty_q   <= '0;
      on_cnt   <= '0;
      on_run   <= '0;
      cur_lvl  <= '0;
      ramp_cnt <= '0;
      ng_en    <= '0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      pwm_cnt  <= pwm_cnt_nx;
      duty_q   <= duty_q_nx;
      on_cnt   <= on_cnt_nx;
      on_run   <= on_run_nx;
      cur_lvl  <= cur_lvl_nx;
      ramp_cnt <= ramp_cnt_nx;
      ng_en    <= therm;
      busy     <= enable && (state == PULSE);
      fault    <= enable && (state == FLT);
    end
  end

endmodule

// File: tb/tb_ir_sink_pwm_ctrl.sv
// tb_ir_sink_pwm_ctrl: directed bench for ir_sink_pwm_ctrl.
// Default parameters: NGRP=8, PWM_W=8, TIME_W=16, RAMP_SH=2.
module tb_ir_sink_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        trig = 1'b0;
  logic [3:0]  level = 4'd0;
  logic [7:0]  duty = 8'd0;
  logic [15:0] pulse_len = 16'd0;
  logic [15:0] max_on = 16'd0;
  logic [7:0]  ng_en;
  logic        busy;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  ir_sink_pwm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .trig(trig), .level(level), .duty(duty),
    .pulse_len(pulse_len), .max_on(max_on),
    .ng_en(ng_en), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // j-th on-cycle of an interval, ramp of 4 cycles per group
  function automatic logic [7:0] ramp_exp(int j, int lv);
    int k;
    k = (j - 1) / 4 + 1;
    if (k > lv) k = lv;
    return 8'((1 << k) - 1);
  endfunction

  task automatic go_idle();
    enable = 1'b0;
    trig = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({ng_en, busy, fault} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_state: got ng_en=%h busy=%b fault=%b want 0",
               ng_en, busy, fault);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_oneshot();
    logic [7:0] e;
    enable = 1'b1; mode = 1'b1; level = 4'd8;
    pulse_len = 16'd40; max_on = 16'd0; trig = 1'b1;
    tick();
    n_cmp++;
    if ({ng_en, busy} !== 9'd0) begin
      n_bad++;
      $display("FAIL oneshot_lat: got ng_en=%h busy=%b want 00/0", ng_en, busy);
    end
    for (int j = 1; j <= 40; j++) begin
      tick();
      e = (j <= 28) ? ramp_exp(j, 8) : 8'hFF;
      n_cmp++;
      if (ng_en !== e || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL oneshot_c%0d: got ng_en=%h busy=%b want %h/1",
                 j, ng_en, busy, e);
      end
    end
    trig = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++;
      if ({ng_en, busy} !== 9'd0) begin
        n_bad++;
        $display("FAIL oneshot_end%0d: got ng_en=%h busy=%b want 00/0",
                 j, ng_en, busy);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int ons;
    enable = 1'b1; mode = 1'b1; level = 4'd8;
    pulse_len = 16'd40; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ng_en, busy, fault} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_async: got ng_en=%h busy=%b fault=%b want 0",
               ng_en, busy, fault);
    end
    tick();
    rst_n = 1'b1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    n_cmp++;
    if (ng_en !== 8'h01 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_retrig: got ng_en=%h busy=%b want 01/1", ng_en, busy);
    end
    ons = 1;
    for (int j = 0; j < 60 && busy === 1'b1; j++) begin
      tick();
      if (ng_en !== 8'h00) ons++;
    end
    n_cmp++;
    if (ons != 40 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulse_len: got %0d on-cycles busy=%b want 40/0",
               ons, busy);
    end
    go_idle();
  endtask

  task automatic test_pwm();
    logic [7:0] e;
    int jj, d;
    enable = 1'b1; mode = 1'b0; level = 4'd3; duty = 8'd64;
    tick();
    n_cmp++;
    if (ng_en !== 8'h00) begin
      n_bad++;
      $display("FAIL pwm_entry: got ng_en=%h want 00", ng_en);
    end
    for (int j = 1; j <= 532; j++) begin
      tick();
      jj = (j - 1) % 256 + 1;
      d = (j <= 256) ? 64 : 128;
      e = (jj <= d) ? ramp_exp(jj, 3) : 8'h00;
      n_cmp++;
      if (ng_en !== e) begin
        n_bad++;
        $display("FAIL pwm_c%0d: got ng_en=%h want %h", j, ng_en, e);
      end
      if (j == 100) duty = 8'd128;
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (ng_en !== 8'h00) begin
      n_bad++;
      $display("FAIL pwm_disable: got ng_en=%h want 00", ng_en);
    end
    go_idle();
  endtask

  task automatic test_duty_zero();
    int nz;
    enable = 1'b1; mode = 1'b0; level = 4'd8; duty = 8'd0;
    nz = 0;
    for (int j = 0; j < 300; j++) begin
      tick();
      if (ng_en !== 8'h00) nz++;
    end
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL duty_zero: got %0d on-cycles want 0", nz);
    end
    go_idle();
  endtask

  task automatic test_protection();
    enable = 1'b1; mode = 1'b1; level = 4'd8;
    pulse_len = 16'd200; max_on = 16'd100; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      tick();
      n_cmp++;
      if (ng_en === 8'h00 || fault !== 1'b0) begin
        n_bad++;
        $display("FAIL prot_on%0d: got ng_en=%h fault=%b want nonzero/0",
                 j, ng_en, fault);
      end
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      n_cmp++;
      if (ng_en !== 8'h00 || fault !== 1'b1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL prot_fault%0d: got ng_en=%h fault=%b busy=%b want 00/1/0",
                 j, ng_en, fault, busy);
      end
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (fault !== 1'b0 || ng_en !== 8'h00) begin
      n_bad++;
      $display("FAIL prot_clear: got fault=%b ng_en=%h want 0/00", fault, ng_en);
    end
    enable = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({ng_en, busy, fault} !== 10'd0) begin
      n_bad++;
      $display("FAIL prot_idle: got ng_en=%h busy=%b fault=%b want 0",
               ng_en, busy, fault);
    end
    max_on = 16'd0;
    go_idle();
  endtask

  task automatic test_zero_len();
    enable = 1'b1; mode = 1'b1; level = 4'd8;
    pulse_len = 16'd0; trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    n_cmp++;
    if (ng_en !== 8'h00 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_len_busy: got ng_en=%h busy=%b want 00/1", ng_en, busy);
    end
    tick();
    n_cmp++;
    if (ng_en !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len_end: got ng_en=%h busy=%b want 00/0", ng_en, busy);
    end
    go_idle();
  endtask

  task automatic test_level_zero();
    int nb, bad;
    enable = 1'b1; mode = 1'b1; level = 4'd0;
    pulse_len = 16'd10; max_on = 16'd1; trig = 1'b1;
    tick();
    trig = 1'b0;
    nb = 0; bad = 0;
    for (int j = 0; j < 14; j++) begin
      tick();
      if (busy === 1'b1) nb++;
      if (ng_en !== 8'h00 || fault !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || nb != 10) begin
      n_bad++;
      $display("FAIL level_zero: got %0d bad cycles, busy %0d want 0, 10",
               bad, nb);
    end
    max_on = 16'd0;
    go_idle();
  endtask

  task automatic test_level_drop();
    logic [7:0] e;
    enable = 1'b1; mode = 1'b1; level = 4'd8;
    pulse_len = 16'd40; trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      e = (j <= 20) ? ramp_exp(j, 8) : 8'h03;
      n_cmp++;
      if (ng_en !== e) begin
        n_bad++;
        $display("FAIL drop_c%0d: got ng_en=%h want %h", j, ng_en, e);
      end
      if (j == 20) level = 4'd2;
    end
    tick();
    n_cmp++;
    if ({ng_en, busy} !== 9'd0) begin
      n_bad++;
      $display("FAIL drop_end: got ng_en=%h busy=%b want 00/0", ng_en, busy);
    end
    go_idle();
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_oneshot();
    test_reset_mid();
    test_pwm();
    test_duty_zero();
    test_protection();
    test_zero_len();
    test_level_zero();
    test_level_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
